// File: rtl/dds_lookup_reader.sv
// ---------------------------------------------------------------------------
// dds_lookup_reader
//   Direct digital synthesis front end. A phase accumulator steps by a
//   programmable tuning word, and its top ADDR_W bits plus a phase offset
//   address an external lookup RAM. The RAM has one cycle of read latency,
//   so samples are registered two edges after their address.
//
//   States: IDLE (outputs quiet), FILL (2 cycles, pipeline priming), RUN.
//   The first address is issued on the IDLE->FILL edge, so the first sample
//   lands on the FILL->RUN edge and sample_valid_o has no gaps in RUN.
//
//   Optional build macro: DDS_READER_DITHER_EN adds a 16-bit LFSR (taps
//   16,14,13,11, seed 0xACE1) to the accumulator before the address bits
//   are taken. The accumulator itself is never dithered.
//
// Ports
//   clk_i            clock (RAM read port shares it)
//   reset_n_i        asynchronous active-low reset
//   enable_i         level: 1 = generate, 0 = idle
//   tuning_word_i    phase increment, captured when tuning_load_i = 1
//   tuning_load_i    one-cycle load strobe
//   phase_offset_i   address offset, sampled every cycle
//   phase_clear_i    one-cycle strobe, zeroes the accumulator
//   ram_address_o    registered RAM read address
//   ram_chipselect_o high in FILL and RUN
//   ram_readdata_i   RAM read data
//   sample_out_o     registered sample
//   sample_valid_o   sample_out_o holds a valid sample (every RUN cycle)
//   wrap_o           one-cycle pulse on accumulator carry-out
// ---------------------------------------------------------------------------
module dds_lookup_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic [ACC_W-1:0]  tuning_word_i,
    input  logic              tuning_load_i,
    input  logic [ADDR_W-1:0] phase_offset_i,
    input  logic              phase_clear_i,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic              ram_chipselect_o,
    input  logic [DATA_W-1:0] ram_readdata_i,
    output logic [DATA_W-1:0] sample_out_o,
    output logic              sample_valid_o,
    output logic              wrap_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int LO_W = ACC_W - ADDR_W;

    state_t              state_q;
    logic                fill_cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    tuning_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                cs_q;
    logic [DATA_W-1:0]   sample_q;
    logic                valid_q;
    logic                wrap_q;

    // Accumulation with the carry kept as the extra MSB.
    logic [ACC_W:0]      acc_sum;
    logic [ADDR_W-1:0]   addr_base;
    logic [ADDR_W-1:0]   addr_d;

    assign acc_sum = {1'b0, acc_q} + {1'b0, tuning_q};

`ifdef DDS_READER_DITHER_EN
    logic [15:0] lfsr_q;
    logic        dith_carry;

    // Only the carry from the low (sub-address) bits into the address
    // field matters; computing it as a compare avoids a half-used sum.
    assign dith_carry = ({1'b0, acc_q[LO_W-1:0]} + {{(LO_W+1-16){1'b0}}, lfsr_q})
                        > {1'b0, {LO_W{1'b1}}};
    assign addr_base  = acc_q[ACC_W-1 -: ADDR_W] + {{(ADDR_W-1){1'b0}}, dith_carry};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            lfsr_q <= 16'hACE1;
        else if (enable_i)
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`else
    assign addr_base = acc_q[ACC_W-1 -: ADDR_W];
`endif

    assign addr_d = addr_base + phase_offset_i;

    // With enable high the block is either entering FILL or staying in
    // FILL/RUN, so every enabled edge advances the phase pipeline.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            fill_cnt_q <= 1'b0;
            acc_q      <= '0;
            tuning_q   <= '0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            if (tuning_load_i)
                tuning_q <= tuning_word_i;

            if (!enable_i) begin
                state_q    <= IDLE;
                fill_cnt_q <= 1'b0;
                acc_q      <= '0;
                addr_q     <= '0;
                cs_q       <= 1'b0;
                sample_q   <= '0;
                valid_q    <= 1'b0;
                wrap_q     <= 1'b0;
            end else begin
                cs_q   <= 1'b1;
                addr_q <= addr_d;
                acc_q  <= phase_clear_i ? '0 : acc_sum[ACC_W-1:0];
                wrap_q <= acc_sum[ACC_W] & ~phase_clear_i;
                case (state_q)
                    IDLE: begin
                        state_q    <= FILL;
                        fill_cnt_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end
                    FILL: begin
                        if (fill_cnt_q) begin
                            state_q  <= RUN;
                            valid_q  <= 1'b1;
                            sample_q <= ram_readdata_i;
                        end else begin
                            fill_cnt_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        valid_q  <= 1'b1;
                        sample_q <= ram_readdata_i;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ram_address_o    = addr_q;
    assign ram_chipselect_o = cs_q;
    assign sample_out_o     = sample_q;
    assign sample_valid_o   = valid_q;
    assign wrap_o           = wrap_q;

endmodule
